// File: rtl/uart_receiver.sv
// APB-mapped 8N1 UART receiver with a small receive FIFO; `UART_RX_PARITY_EN adds an even-parity bit.
// Latency: a byte is visible the cycle after its stop bit is sampled; APB has no wait states.
// Backpressure: none on the serial line; a byte arriving while the FIFO is full is dropped and OVR is set.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] padd,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    input  logic        i_rx_serial,
    output logic        o_rx_valid
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q, rx_prev_q;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_bad_q, par_bad_d;
    logic            push_req, ferr_set, perr_set;
    logic            bit_done, rx_s;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            empty, full, push, pop;
    logic            ovr_q, ferr_q, perr_q, ovr_set;
    logic            access, rd_acc, wr_acc, clr;
    logic [1:0]      sel;
    logic [31:0]     rdata;
    logic            unused_ok;

    assign rx_s     = sync2_q;
    assign bit_done = (clk_cnt_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        push_req  = 1'b0;
        ferr_set  = 1'b0;
        perr_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                par_bad_d = 1'b0;
                if (rx_prev_q && !rx_s) state_d = ST_START;
            end
            // Mid-start-bit check rejects glitches shorter than half a bit.
            ST_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    state_d   = ST_STOP;
                    if ((^shift_q) != rx_s) begin
                        perr_set  = 1'b1;
                        par_bad_d = 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    state_d   = ST_IDLE;
                    if (rx_s) push_req = !par_bad_q;
                    else      ferr_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            sync1_q   <= i_rx_serial;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end
    end

    assign access = psel & penable;
    assign rd_acc = access & ~pwrite;
    assign wr_acc = access & pwrite;
    assign sel    = padd[3:2];
    assign clr    = wr_acc && (sel == 2'd1);

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop     = rd_acc && (sel == 2'd0) && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push    = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ovr_q   <= (ovr_q  & ~(clr & pwdata[1])) | ovr_set;
            ferr_q  <= (ferr_q & ~(clr & pwdata[2])) | ferr_set;
            perr_q  <= (perr_q & ~(clr & pwdata[3])) | perr_set;
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr_q] <= shift_q;
    end

    always_comb begin
        rdata = '0;
        case (sel)
            2'd0:    rdata = empty ? 32'd0 : {24'd0, mem[rd_ptr_q]};
            2'd1:    rdata = {28'd0, perr_q, ferr_q, ovr_q, !empty};
            default: rdata = '0;
        endcase
    end

    // Gated by rst so the bus outputs drop the instant reset asserts.
    assign prdata     = (rd_acc && rst) ? rdata : 32'd0;
    assign pready     = access & rst;
    assign o_rx_valid = !empty;

    assign unused_ok = &{1'b0, padd[31:4], padd[1:0], pwdata[31:4], pwdata[0]};
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: serial frames driven bit by bit, registers read over APB.
module tb_uart_receiver;
    logic        pclk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] padd, pwdata, prdata;
    logic        pready, i_rx_serial, o_rx_valid;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_RSVD = 32'h8;

    uart_receiver #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
        .pclk(pclk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .padd(padd), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .i_rx_serial(i_rx_serial), .o_rx_valid(o_rx_valid)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; padd = addr;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        data = prdata;
        rdy  = pready;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; padd = addr; pwdata = data;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic hold_bit(input logic b);
        i_rx_serial = b;
        repeat (8) @(negedge pclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_en, input logic par);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        if (par_en) hold_bit(par);
        hold_bit(stop);
        i_rx_serial = 1'b1;
        repeat (6) @(negedge pclk);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        r;
        apb_read(addr, d, r);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic        r;
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        padd = '0; pwdata = '0; i_rx_serial = 1'b1;
        #1;
        check("reset_valid", {31'd0, o_rx_valid}, 32'd0);
        check("reset_prdata", prdata, 32'd0);
        check("reset_pready", {31'd0, pready}, 32'd0);
        repeat (3) @(negedge pclk);
        rst = 1'b1;
        repeat (4) @(negedge pclk);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5_valid", {31'd0, o_rx_valid}, 32'd1);
        apb_read(A_STAT, d, r);
        check("a5_status", d, 32'h1);
        check("a5_pready", {31'd0, r}, 32'd1);
        read_chk("rsvd_read", A_RSVD, 32'h0);
        read_chk("a5_rxdata", A_DATA, 32'h0000_00A5);
        read_chk("a5_status_after", A_STAT, 32'h0);
        check("a5_valid_after", {31'd0, o_rx_valid}, 32'd0);

        i_rx_serial = 1'b0;
        repeat (2) @(negedge pclk);
        i_rx_serial = 1'b1;
        repeat (20) @(negedge pclk);
        read_chk("glitch_status", A_STAT, 32'h0);
        check("glitch_valid", {31'd0, o_rx_valid}, 32'd0);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge pclk);
        read_chk("ferr_status", A_STAT, 32'h4);
        check("ferr_valid", {31'd0, o_rx_valid}, 32'd0);
        apb_write(A_STAT, 32'h4);
        read_chk("ferr_cleared", A_STAT, 32'h0);

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        read_chk("ovr_status", A_STAT, 32'h3);
        for (int i = 1; i <= 4; i++) read_chk($sformatf("ovr_rd%0d", i), A_DATA, 32'(i));
        read_chk("ovr_rd5_empty", A_DATA, 32'h0);
        read_chk("ovr_status_empty", A_STAT, 32'h2);
        apb_write(A_STAT, 32'h2);
        read_chk("ovr_cleared", A_STAT, 32'h0);

        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check("pre_rst_valid", {31'd0, o_rx_valid}, 32'd1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b1);
        i_rx_serial = 1'b0;
        repeat (3) @(negedge pclk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; padd = A_STAT;
        rst = 1'b0;
        #1;
        check("midrst_valid", {31'd0, o_rx_valid}, 32'd0);
        check("midrst_prdata", prdata, 32'd0);
        check("midrst_pready", {31'd0, pready}, 32'd0);
        i_rx_serial = 1'b1;
        repeat (3) @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge pclk);
        read_chk("postrst_status", A_STAT, 32'h0);
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        read_chk("postrst_rxdata", A_DATA, 32'h0000_0077);
        read_chk("postrst_status2", A_STAT, 32'h0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        read_chk("par_bad_status", A_STAT, 32'h8);
        check("par_bad_valid", {31'd0, o_rx_valid}, 32'd0);
        apb_write(A_STAT, 32'h8);
        send_frame(8'h03, 1'b1, 1'b1, 1'b0);
        read_chk("par_ok_status", A_STAT, 32'h1);
        read_chk("par_ok_rxdata", A_DATA, 32'h0000_0003);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, pclk cycles per serial bit (even, >=4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-003 SHALL have port pclk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port psel  input  1  APB slave select.
REQ-006 SHALL have port penable  input  1  APB access phase.
REQ-007 SHALL have port pwrite  input  1  APB direction, 1 = write.
REQ-008 SHALL have port padd  input  32  APB address; only bits [3:2] decoded.
REQ-009 SHALL have port pwdata  input  32  APB write data.
REQ-010 SHALL have port prdata  output  32  APB read data.
REQ-011 SHALL have port pready  output  1  APB ready.
REQ-012 SHALL have port i_rx_serial  input  1  asynchronous serial line, idle high.
REQ-013 SHALL have port o_rx_valid  output  1  high while the FIFO is non-empty.

Function
REQ-014 SHALL pass i_rx_serial through a two-flop synchronizer (both flops reset to 1) before any use.
REQ-015 SHALL frame 8N1: one low start bit, 8 data bits LSB first, one high stop bit.
REQ-016 SHALL implement states IDLE, START, DATA, STOP (plus PARITY per REQ-031), encoded in a 3-bit register.
REQ-017 IDLE -> START on a synchronized high-to-low transition; bit counter and cycle counter cleared.
REQ-018 START: after CLKS_PER_BIT/2 cycles resample; low -> DATA, high -> IDLE (glitch rejected, nothing recorded).
REQ-019 DATA: sample every CLKS_PER_BIT cycles into shift register; after the 8th sample -> STOP.
REQ-020 STOP: after CLKS_PER_BIT cycles sample; high -> push byte, low -> set FERR and discard byte; either case -> IDLE.
REQ-021 Push when FIFO full SHALL drop the new byte, keep FIFO contents, set OVR.
REQ-022 Register map (padd[3:2]): 0 = RXDATA (read: {24'b0, oldest byte}); 1 = STATUS {28'b0, PERR, FERR, OVR, NOT_EMPTY}; 2,3 = read 0, writes ignored.
REQ-023 pready SHALL be 1 in every access phase (no wait states); 0 otherwise.
REQ-024 prdata SHALL be valid during the access phase of a read and 0 at all other times.
REQ-025 A read of RXDATA SHALL pop exactly one entry, once per transfer, at the access-phase edge; reading when empty returns 0 and pops nothing.
REQ-026 Writing STATUS SHALL clear each of OVR, FERR, PERR whose pwdata bit is 1; NOT_EMPTY is read-only.
REQ-027 Simultaneous push and pop in one cycle SHALL both take effect; occupancy unchanged, including when full.
REQ-028 Error flags SHALL be sticky; a set event in the same cycle as a clear SHALL win.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an occupancy counter of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-030 rst low SHALL immediately force: state IDLE, counters 0, FIFO empty, all flags 0, prdata 0, pready 0, o_rx_valid 0; a frame in progress is abandoned.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: PARITY state between DATA and STOP samples an even-parity bit; mismatch sets PERR and discards the byte (stop bit still sampled).
REQ-032 Macro undefined: no PARITY state, frame is 8N1, STATUS bit 3 (PERR) reads 0 and is never set.

Verification
REQ-033 Frame 0xA5, valid stop -> o_rx_valid=1, STATUS=0x1, RXDATA read=0x000000A5, then STATUS=0x0.
REQ-034 Line low for 2 cycles then high (CLKS_PER_BIT=8) -> no push, STATUS=0x0, state IDLE.
REQ-035 Frame 0x3C with stop bit 0 -> FERR=1 (STATUS=0x4), FIFO empty; write STATUS 0x4 -> STATUS=0x0.
REQ-036 Five frames 0x01..0x05 without reads -> reads return 0x01..0x04 in order, OVR=1, fifth read returns 0.
REQ-037 Reset asserted mid-DATA of a frame -> all outputs 0 at once; next full frame 0x77 received correctly.
REQ-038 With UART_RX_PARITY_EN, frame 0x03 with parity bit 1 -> PERR=1, no push; parity 0 -> 0x03 received.
